// File: rtl/ddr_tx_pkg.sv
// Shared types and defaults for the DDR transmit serializer and its companion receive side.
// Both sides take their beat-counter width from beat_cnt_w so they agree on the beat count.
package ddr_tx_pkg;

  localparam int   DEF_DATA_W   = 8;
  localparam logic DEF_IDLE_BIT = 1'b1;

  typedef enum logic {
    IDLE,
    SHIFT
  } tx_state_e;

  // Width of a counter that has to reach DATA_W/2 - 1.
  function automatic int beat_cnt_w(input int dataW);
    return (dataW < 4) ? 1 : $clog2(dataW / 2);
  endfunction

endpackage

// File: rtl/ddr_tx_serializer_if.sv
// Word-in / DDR-bit-pair-out bundle between a word source and the serializer.
interface ddr_tx_serializer_if
  import ddr_tx_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) ();

  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              d_rise;
  logic              d_fall;
  logic              tx_active;
  logic              frame_start;
  logic [15:0]       word_cnt;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  d_rise,
    input  d_fall,
    input  tx_active,
    input  frame_start,
    input  word_cnt
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output d_rise,
    output d_fall,
    output tx_active,
    output frame_start,
    output word_cnt
  );

endinterface

// File: rtl/ddr_hold_buf.sv
// One-entry word buffer with a valid flag and a registered not-full output.
// The receive side reuses it, so it has no knowledge of the beat timing.
module ddr_hold_buf
  import ddr_tx_pkg::*;
#(
  parameter int WIDTH = DEF_DATA_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             rd_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             valid_o,
  output logic             notFull_o
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             notFull_q, notFull_d;

  // notFull is precomputed from the next valid, so it follows the buffer with no extra lag.
  always_comb begin
    data_d    = wr_i ? wdata_i : data_q;
    valid_d   = wr_i | (valid_q & ~rd_i);
    notFull_d = ~valid_d;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      notFull_q <= 1'b0;
    end else begin
      data_q    <= data_d;
      valid_q   <= valid_d;
      notFull_q <= notFull_d;
    end
  end

  assign rdata_o   = data_q;
  assign valid_o   = valid_q;
  assign notFull_o = notFull_q;

endmodule

// File: rtl/ddr_tx_serializer.sv
// Sends each DATA_W-bit word as DATA_W/2 (rise, fall) bit pairs, LSB first.
// One word can wait in a hold buffer, so a source that keeps valid high sees no gaps.
module ddr_tx_serializer
  import ddr_tx_pkg::*;
#(
  parameter int   DATA_W   = DEF_DATA_W,
  parameter logic IDLE_BIT = DEF_IDLE_BIT
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  ddr_tx_serializer_if.slave tx_if
);

  localparam int            BEATS     = DATA_W / 2;
  localparam int            BW        = beat_cnt_w(DATA_W);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  tx_state_e         state_q, state_d;
  logic [BW-1:0]     beatCnt_q, beatCnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [15:0]       wordCnt_q, wordCnt_d;
  logic              dRise_q, dRise_d;
  logic              dFall_q, dFall_d;
  logic              txActive_q, txActive_d;
  logic              frameStart_q, frameStart_d;

  logic              accept;
  logic              lastBeat;
  logic              directLoad;
  logic              holdWr;
  logic              holdRd;
  logic              loadShift;
  logic              holdValid;
  logic              holdNotFull;
  logic [DATA_W-1:0] holdData;
  logic [DATA_W-1:0] loadData;

  ddr_hold_buf #(
    .WIDTH(DATA_W)
  ) u_hold (
    .clk_i    (sys_clk),
    .rst_ni   (sys_rst_n),
    .wr_i     (holdWr),
    .wdata_i  (tx_if.in_data),
    .rd_i     (holdRd),
    .rdata_o  (holdData),
    .valid_o  (holdValid),
    .notFull_o(holdNotFull)
  );

  // A full hold buffer blocks accept, so its word always wins the last-beat edge.
  assign accept     = tx_if.in_valid & holdNotFull;
  assign lastBeat   = (state_q == SHIFT) && (beatCnt_q == LAST_BEAT);
  assign directLoad = accept & ((state_q == IDLE) | (lastBeat & ~holdValid));
  assign holdWr     = accept & ~directLoad;
  assign holdRd     = lastBeat & holdValid;
  assign loadShift  = directLoad | holdRd;
  assign loadData   = holdRd ? holdData : tx_if.in_data;

  always_comb begin
    state_d   = state_q;
    beatCnt_d = beatCnt_q;
    shift_d   = shift_q;
    wordCnt_d = wordCnt_q;

    if (loadShift) begin
      state_d   = SHIFT;
      beatCnt_d = '0;
      shift_d   = loadData;
      wordCnt_d = wordCnt_q + 16'd1;
    end else if (lastBeat) begin
      state_d   = IDLE;
      beatCnt_d = '0;
    end else if (state_q == SHIFT) begin
      beatCnt_d = beatCnt_q + BW'(1);
      shift_d   = shift_q >> 2;
    end

    // Outputs take the bits of the next beat, so they change at the edge that loads or shifts.
    txActive_d   = (state_d == SHIFT);
    dRise_d      = txActive_d ? shift_d[0] : IDLE_BIT;
    dFall_d      = txActive_d ? shift_d[1] : IDLE_BIT;
    frameStart_d = loadShift;
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q      <= IDLE;
      beatCnt_q    <= '0;
      shift_q      <= '0;
      wordCnt_q    <= '0;
      dRise_q      <= IDLE_BIT;
      dFall_q      <= IDLE_BIT;
      txActive_q   <= 1'b0;
      frameStart_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      beatCnt_q    <= beatCnt_d;
      shift_q      <= shift_d;
      wordCnt_q    <= wordCnt_d;
      dRise_q      <= dRise_d;
      dFall_q      <= dFall_d;
      txActive_q   <= txActive_d;
      frameStart_q <= frameStart_d;
    end
  end

  assign tx_if.in_ready    = holdNotFull;
  assign tx_if.d_rise      = dRise_q;
  assign tx_if.d_fall      = dFall_q;
  assign tx_if.tx_active   = txActive_q;
  assign tx_if.frame_start = frameStart_q;
  assign tx_if.word_cnt    = wordCnt_q;

endmodule
